// File: rtl/reg_file_pkg.sv
// Shared constants for the scoreboarded register file: default geometry
// and the 16-entry reset image. Entries past the image reset to zero.
package reg_file_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_SPEC_IDX = 14;

    localparam int RST_N = 16;

    localparam logic [15:0] RST_VALS [RST_N] = '{
        16'h7b18, 16'h245b, 16'hff0f, 16'hf0ff,
        16'h0051, 16'h6666, 16'h00ff, 16'hff88,
        16'h0000, 16'h0000, 16'h3099, 16'hcccc,
        16'h0002, 16'h0011, 16'h0000, 16'h0000
    };

    // Reset value for any register index; indices beyond the image give 0.
    function automatic logic [15:0] rst_val(input int unsigned idx);
        logic [3:0] w_i;
        w_i = idx[3:0];
        if (idx < RST_N) return RST_VALS[w_i];
        return 16'h0000;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one bit per register marking an outstanding producer.
// Issue sets, writeback clears, and a same-edge set beats the clear so a
// newly issued producer is never lost.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_iss_en,
    input  logic [ADDR_W-1:0]        i_iss_addr,
    input  logic                     i_clr_en,
    input  logic [ADDR_W-1:0]        i_clr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD-1:0]        o_rd_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] r_busy;

    // Clear on writeback first, then set on issue so set wins on collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (i_clr_en) r_busy[i_clr_addr] <= 1'b0;
            if (i_iss_en) r_busy[i_iss_addr] <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_look
        assign o_rd_busy[p] = r_busy[i_rd_addr[p*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with busy scoreboard and a dedicated side
// write port for register SPEC_IDX (side port wins over writeback).
// Optional forwarding of same-cycle writes: define REG_FILE_BYPASS_EN.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int SPEC_IDX = DEF_SPEC_IDX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     stall,
    output logic [DATA_W-1:0]        spec_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     spec_we,
    input  logic [DATA_W-1:0]        spec_wdata,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SPEC_A = ADDR_W'(SPEC_IDX);

    logic [DATA_W-1:0]             r_mem [DEPTH];
    logic [NUM_RD-1:0]             w_sb_busy;
    logic [NUM_RD-1:0][DATA_W-1:0] w_rd_data;
    logic [NUM_RD-1:0]             w_rd_busy;

    // Storage: reset image, then writeback, with the side port landing last
    // so it overrides a writeback aimed at the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= DATA_W'(rst_val(i));
        end else begin
            if (wr_en)   r_mem[wr_addr] <= wr_data;
            if (spec_we) r_mem[SPEC_A]  <= spec_wdata;
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_iss_en   (iss_en),
        .i_iss_addr (iss_addr),
        .i_clr_en   (wr_en),
        .i_clr_addr (wr_addr),
        .i_rd_addr  (rd_addr),
        .o_rd_busy  (w_sb_busy)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_d;
        logic              w_b;
        assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];
`ifdef REG_FILE_BYPASS_EN
        // Forward this cycle's write; side port outranks writeback, and a
        // matching writeback retires the producer so busy is masked.
        always_comb begin
            w_d = r_mem[w_addr];
            w_b = w_sb_busy[p];
            if (wr_en && wr_addr == w_addr) begin
                w_d = wr_data;
                w_b = 1'b0;
            end
            if (spec_we && w_addr == SPEC_A) w_d = spec_wdata;
        end
`else
        // Plain lookup from stored state.
        always_comb begin
            w_d = r_mem[w_addr];
            w_b = w_sb_busy[p];
        end
`endif
        assign w_rd_data[p] = w_d;
        assign w_rd_busy[p] = w_b;
    end

`ifdef REG_FILE_BYPASS_EN
    // Side-register view forwarded the same way as the read ports.
    always_comb begin
        spec_data = r_mem[SPEC_A];
        if (wr_en && wr_addr == SPEC_A) spec_data = wr_data;
        if (spec_we) spec_data = spec_wdata;
    end
`else
    // Side-register view straight from storage.
    always_comb begin
        spec_data = r_mem[SPEC_A];
    end
`endif

    assign rd_data = w_rd_data;
    assign rd_busy = w_rd_busy;
    assign stall   = |w_rd_busy;

endmodule
